// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard detector tracking in-flight register writes in a DEPTH-entry shift scoreboard.
// Optional macro HAZARD_SCOREBOARD_FORWARD_EN enables forwarding selects; without it every RAW match stalls.
module hazard_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16,
  parameter int FW_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] rsaddr_ID,
  input  logic [ADDR_W-1:0] rtaddr_ID,
  input  logic              rs_used_ID,
  input  logic              rt_used_ID,
  input  logic [ADDR_W-1:0] rdaddr_ID,
  input  logic              RegWrite_ID,
  input  logic              MemRead_ID,
  input  logic              flush,
  output logic              DataHazard,
  output logic [FW_W-1:0]   fwd_rs,
  output logic [FW_W-1:0]   fwd_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH-1:0]  sb_valid;
  logic [ADDR_W-1:0] sb_rd [DEPTH];
  logic [DEPTH-1:0]  rs_match;
  logic [DEPTH-1:0]  rt_match;

  // A source of r0 never matches, so an r0 writer is never treated as a producer.
  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs_match[i] = rs_used_ID && (rsaddr_ID != '0) && sb_valid[i] && (sb_rd[i] == rsaddr_ID);
      rt_match[i] = rt_used_ID && (rtaddr_ID != '0) && sb_valid[i] && (sb_rd[i] == rtaddr_ID);
    end
  end

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
  logic [DEPTH-1:0] sb_load;
  logic [FW_W-1:0]  rs_sel;
  logic [FW_W-1:0]  rt_sel;
  logic             rs_stall;
  logic             rt_stall;

  // Scan oldest to youngest so the lowest-index (youngest) producer wins.
  always_comb begin
    rs_sel = '0;
    rt_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rs_match[i]) rs_sel = FW_W'(i + 1);
      if (rt_match[i]) rt_sel = FW_W'(i + 1);
    end
  end

  assign rs_stall   = rs_match[0] && sb_load[0];
  assign rt_stall   = rt_match[0] && sb_load[0];
  assign DataHazard = issue_valid && (rs_stall || rt_stall);
  assign fwd_rs     = (DataHazard || rs_stall) ? '0 : rs_sel;
  assign fwd_rt     = (DataHazard || rt_stall) ? '0 : rt_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_load <= '0;
    end else begin
      sb_load <= {sb_load[DEPTH-2:0], MemRead_ID};
    end
  end
`else
  logic unused_mem_read;

  assign unused_mem_read = MemRead_ID;
  assign DataHazard      = issue_valid && ((|rs_match) || (|rt_match));
  assign fwd_rs          = '0;
  assign fwd_rt          = '0;
`endif

  // A stalled issue enters EX as a bubble; flush clears every entry including the incoming one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_valid  <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      if (flush) begin
        sb_valid <= '0;
      end else begin
        sb_valid <= {sb_valid[DEPTH-2:0], issue_valid && !DataHazard && RegWrite_ID};
      end
      sb_rd[0] <= rdaddr_ID;
      for (int i = 1; i < DEPTH; i++) sb_rd[i] <= sb_rd[i-1];
      if (DataHazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard (DEPTH=2, CNT_W=3); expectations follow
// the HAZARD_SCOREBOARD_FORWARD_EN setting of the build.
module tb_hazard_scoreboard;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 3;
  localparam int FW_W   = 2;

  typedef struct packed {
    logic             dh;
    logic [FW_W-1:0]  frs;
    logic [FW_W-1:0]  frt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] rsaddr_ID = '0;
  logic [ADDR_W-1:0] rtaddr_ID = '0;
  logic              rs_used_ID = 1'b0;
  logic              rt_used_ID = 1'b0;
  logic [ADDR_W-1:0] rdaddr_ID = '0;
  logic              RegWrite_ID = 1'b0;
  logic              MemRead_ID = 1'b0;
  logic              flush = 1'b0;
  logic              DataHazard;
  logic [FW_W-1:0]   fwd_rs;
  logic [FW_W-1:0]   fwd_rt;
  logic [CNT_W-1:0]  stall_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  hazard_scoreboard #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid),
    .rsaddr_ID(rsaddr_ID), .rtaddr_ID(rtaddr_ID),
    .rs_used_ID(rs_used_ID), .rt_used_ID(rt_used_ID),
    .rdaddr_ID(rdaddr_ID), .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID),
    .flush(flush), .DataHazard(DataHazard), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] sat(input int v);
    return (v > 7) ? 3'd7 : CNT_W'(v);
  endfunction

  task automatic checkOutput(input string nm, input string field,
                             input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", nm, field, act, expv);
    end
  endtask

  // Drive one ID-stage vector just after the edge and queue what the outputs must show this cycle.
  task automatic applyStimulus(input string nm, input logic iv,
                               input logic [2:0] rs, input logic rsu,
                               input logic [2:0] rt, input logic rtu,
                               input logic [2:0] rd, input logic rw, input logic mr,
                               input logic fl, input logic rstn,
                               input logic edh, input logic [1:0] efrs,
                               input logic [1:0] efrt, input logic [2:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    issue_valid = iv;   rsaddr_ID = rs; rs_used_ID = rsu;
    rtaddr_ID = rt;     rt_used_ID = rtu;
    rdaddr_ID = rd;     RegWrite_ID = rw; MemRead_ID = mr;
    flush = fl;         rst_n = rstn;
    e.dh = edh; e.frs = efrs; e.frt = efrt; e.cnt = ecnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are combinational, so every driven cycle presents a result at the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checkOutput(nm, "DataHazard", 8'(DataHazard), 8'(e.dh));
        checkOutput(nm, "fwd_rs", 8'(fwd_rs), 8'(e.frs));
        checkOutput(nm, "fwd_rt", 8'(fwd_rt), 8'(e.frt));
        checkOutput(nm, "stall_cnt", 8'(stall_cnt), 8'(e.cnt));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    repeat (2) @(posedge clk);

    applyStimulus("reset_empty", 1, 3,1, 5,1, 0,0,0, 0,1, 0,0,0, 0);

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    applyStimulus("add_r2",      1, 0,0, 0,0, 2,1,0, 0,1, 0,0,0, 0);
    applyStimulus("fwd_e0",      1, 2,1, 0,0, 0,0,0, 0,1, 0,1,0, 0);
    applyStimulus("fwd_e1",      1, 2,1, 0,0, 0,0,0, 0,1, 0,2,0, 0);
    applyStimulus("load_r4",     1, 0,0, 0,0, 4,1,1, 0,1, 0,0,0, 0);
    applyStimulus("load_use",    1, 0,0, 4,1, 0,0,0, 0,1, 1,0,0, 0);
    applyStimulus("load_fwd",    1, 0,0, 4,1, 0,0,0, 0,1, 0,0,2, 1);
    applyStimulus("w6_a",        1, 0,0, 0,0, 6,1,0, 0,1, 0,0,0, 1);
    applyStimulus("w6_b",        1, 0,0, 0,0, 6,1,0, 0,1, 0,0,0, 1);
    applyStimulus("youngest",    1, 6,1, 0,0, 0,0,0, 0,1, 0,1,0, 1);
    applyStimulus("w0",          1, 0,0, 0,0, 0,1,0, 0,1, 0,0,0, 1);
    applyStimulus("read_r0",     1, 0,1, 0,1, 0,0,0, 0,1, 0,0,0, 1);
    applyStimulus("w7_flush",    1, 0,0, 0,0, 7,1,0, 1,1, 0,0,0, 1);
    applyStimulus("after_flush", 1, 7,1, 7,1, 0,0,0, 0,1, 0,0,0, 1);
    applyStimulus("w3",          1, 0,0, 0,0, 3,1,0, 0,1, 0,0,0, 1);
    applyStimulus("unused_src",  1, 3,0, 3,0, 0,0,0, 0,1, 0,0,0, 1);
    applyStimulus("load_r5",     1, 0,0, 0,0, 5,1,1, 0,1, 0,0,0, 1);
    applyStimulus("use_r5",      1, 5,1, 0,0, 0,0,0, 0,1, 1,0,0, 1);
    applyStimulus("fwd_r5",      1, 5,1, 0,0, 0,0,0, 0,1, 0,2,0, 2);
    applyStimulus("load_r1",     1, 0,0, 0,0, 1,1,1, 0,1, 0,0,0, 2);
    applyStimulus("stall_rst",   1, 1,1, 0,0, 0,0,0, 0,0, 1,0,0, 2);
    applyStimulus("post_rst",    1, 1,1, 0,0, 0,0,0, 0,1, 0,0,0, 0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus("sat_load",  1, 0,0, 0,0, 2,1,1, 0,1, 0,0,0, sat(k));
      applyStimulus("sat_stall", 1, 2,1, 0,0, 0,0,0, 0,1, 1,0,0, sat(k));
      applyStimulus("sat_fwd",   1, 2,1, 0,0, 0,0,0, 0,1, 0,2,0, sat(k + 1));
    end
`else
    applyStimulus("w2",          1, 0,0, 0,0, 2,1,0, 0,1, 0,0,0, 0);
    applyStimulus("stall_e0",    1, 2,1, 0,0, 0,0,0, 0,1, 1,0,0, 0);
    applyStimulus("stall_e1",    1, 2,1, 0,0, 0,0,0, 0,1, 1,0,0, 1);
    applyStimulus("released",    1, 2,1, 0,0, 0,0,0, 0,1, 0,0,0, 2);
    applyStimulus("w3",          1, 0,0, 0,0, 3,1,0, 0,1, 0,0,0, 2);
    applyStimulus("indep_r4",    1, 0,0, 4,1, 0,0,0, 0,1, 0,0,0, 2);
    applyStimulus("rt_e1",       1, 0,0, 3,1, 0,0,0, 0,1, 1,0,0, 2);
    applyStimulus("rt_free",     1, 0,0, 3,1, 0,0,0, 0,1, 0,0,0, 3);
    applyStimulus("w6_a",        1, 0,0, 0,0, 6,1,0, 0,1, 0,0,0, 3);
    applyStimulus("w6_b",        1, 0,0, 0,0, 6,1,0, 0,1, 0,0,0, 3);
    applyStimulus("r6_s1",       1, 6,1, 0,0, 0,0,0, 0,1, 1,0,0, 3);
    applyStimulus("r6_s2",       1, 6,1, 0,0, 0,0,0, 0,1, 1,0,0, 4);
    applyStimulus("r6_free",     1, 6,1, 0,0, 0,0,0, 0,1, 0,0,0, 5);
    applyStimulus("w0",          1, 0,0, 0,0, 0,1,0, 0,1, 0,0,0, 5);
    applyStimulus("read_r0",     1, 0,1, 0,1, 0,0,0, 0,1, 0,0,0, 5);
    applyStimulus("w7_flush",    1, 0,0, 0,0, 7,1,0, 1,1, 0,0,0, 5);
    applyStimulus("after_flush", 1, 7,1, 7,1, 0,0,0, 0,1, 0,0,0, 5);
    applyStimulus("w5",          1, 0,0, 0,0, 5,1,0, 0,1, 0,0,0, 5);
    applyStimulus("no_issue",    0, 5,1, 0,0, 0,0,0, 0,1, 0,0,0, 5);
    applyStimulus("r5_e1",       1, 5,1, 0,0, 0,0,0, 0,1, 1,0,0, 5);
    applyStimulus("r5_free",     1, 5,1, 0,0, 0,0,0, 0,1, 0,0,0, 6);
    applyStimulus("w1",          1, 0,0, 0,0, 1,1,0, 0,1, 0,0,0, 6);
    applyStimulus("stall_rst",   1, 1,1, 0,0, 0,0,0, 0,0, 1,0,0, 6);
    applyStimulus("post_rst",    1, 1,1, 0,0, 0,0,0, 0,1, 0,0,0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus("sat_w2",    1, 0,0, 0,0, 2,1,0, 0,1, 0,0,0, sat(2 * k));
      applyStimulus("sat_s1",    1, 2,1, 0,0, 0,0,0, 0,1, 1,0,0, sat(2 * k));
      applyStimulus("sat_s2",    1, 2,1, 0,0, 0,0,0, 0,1, 1,0,0, sat(2 * k + 1));
      applyStimulus("sat_free",  1, 2,1, 0,0, 0,0,0, 0,1, 0,0,0, sat(2 * k + 2));
    end
`endif
    applyStimulus("sat_hold",    0, 0,0, 0,0, 0,0,0, 0,1, 0,0,0, 7);

    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
